wait_state_ctrl: RTL
====================

Name: wait_state_ctrl

Overview:
Shared-resource sequencer for the CPU's delayed memory path.
- Arbitrates between instruction fetch (IF) and data access (MEM) requesters.
- Grants the bus to one requester at a time.
- Holds the bus for a programmable number of wait states, then pulses a done strobe to the winner.
- Sits between the fetch/execute stages and the memory delay element. Drives the pipeline stall.

Parameters:
CNT_W, 4, width of wait-state counter and CFG_WAIT.
DEFAULT_WAIT, 2, wait-state count loaded into the config register at reset; must fit CNT_W bits.

Ports:
CLK  input  1  system clock, rising-edge.
RST_N  input  1  asynchronous active-low reset.
CFG_WE  input  1  load CFG_WAIT into the wait register.
CFG_WAIT  input  CNT_W  wait states per access.
IF_REQ  input  1  fetch request; level, held until IF_DONE.
MEM_REQ  input  1  data request; level, held until MEM_DONE.
MEM_WR  input  1  data access is a write; sampled with grant.
IF_GNT  output  1  IF owns the bus.
MEM_GNT  output  1  MEM owns the bus.
IF_DONE  output  1  one-cycle completion pulse to IF.
MEM_DONE  output  1  one-cycle completion pulse to MEM.
BUS_EN  output  1  delayed-memory access active.
BUS_WE  output  1  write qualifier, valid while BUS_EN=1.
STALL  output  1  pipeline stall: high when any REQ is pending and its DONE is not asserted this cycle.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (RST_N), released synchronously by the integrator.
- Reset values: state=IDLE, all grants/done/BUS_EN/BUS_WE=0, wait_reg=DEFAULT_WAIT, cnt=0, last_owner=MEM (so IF wins the first tie).
- STALL is combinational from REQ and DONE. All other outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the one that is not last_owner (round-robin).
  - On grant: next cycle GNT=1, BUS_EN=1, BUS_WE=MEM_WR (MEM grant) or 0 (IF grant), cnt=wait_reg, last_owner updated, state=ACCESS.
- ACCESS:
  - BUS_EN=1 and GNT held.
  - cnt==0: go to DONE.
  - Otherwise: cnt decrements by 1.
  - BUS_EN is high for exactly wait_reg+1 cycles.
- DONE:
  - The owner's DONE pulses for one cycle; GNT stays high for that cycle; BUS_EN=0.
  - Next cycle: IDLE.
  - A request still high in IDLE is re-arbitrated, so back-to-back accesses take one idle cycle between them.
- Latency: request sampled in cycle T → GNT at T+1 → DONE at T+wait_reg+2.
- CFG_WE:
  - Writable in any state; wait_reg updates on the next edge.
  - An in-flight cnt is unaffected; the new value applies from the next grant.
  - CFG_WE in the same cycle as an IDLE grant: the grant loads the OLD wait_reg.
- CFG_WAIT=0: single-cycle bus access; DONE at T+2.
- Max CFG_WAIT=2^CNT_W−1; no wrap-around. The counter never decrements below 0.
- Requester drops REQ during ACCESS: the access runs to completion and DONE still pulses. The requester must ignore it.
- New request arriving during ACCESS/DONE: waits; no preemption.
- RST_N asserted mid-access: all outputs clear immediately (asynchronous), pending access discarded, wait_reg returns to DEFAULT_WAIT.
- Grants are mutually exclusive; IF_GNT & MEM_GNT is never 1.

Optional Feature:
MEM_PRIO_EN
- Defined: fixed priority; MEM always wins a simultaneous request and last_owner is ignored. IF may starve under continuous MEM traffic (intended for load/store-heavy debug).
- Undefined: round-robin as specified above.
- Ports and timing are identical in both builds.

Test Plan:
- Reset, then IF_REQ=1 alone with default wait 2 → IF_GNT at +1, BUS_EN high 3 cycles, IF_DONE pulse at +4, BUS_WE=0.
- CFG_WE with CFG_WAIT=0, then MEM_REQ=1, MEM_WR=1 → MEM_GNT at +1, BUS_EN=1 and BUS_WE=1 for 1 cycle, MEM_DONE at +2.
- IF_REQ and MEM_REQ held high together (wait=1) → grant order IF, MEM, IF, MEM. Each done at grant+2. One idle cycle between accesses. Grants never overlap.
- Same as previous with MEM_PRIO_EN defined → MEM granted every arbitration and IF_GNT never rises while MEM_REQ=1.
- CFG_WE with CFG_WAIT=5 during an access loaded with wait 2 → current access ends at 3 BUS_EN cycles; the next access gets 6 BUS_EN cycles.
- RST_N pulsed low mid-ACCESS → GNT/BUS_EN drop in the same timestep, state=IDLE, wait_reg=2; a subsequent IF_REQ is served normally.

Source files
------------

// File: rtl/wait_state_ctrl.sv
// Wait-state sequencer: arbitrates IF/MEM requests onto the delayed memory bus and
// holds each access for a programmable wait count. Define MEM_PRIO_EN for fixed MEM priority.
module wait_state_ctrl #(
   parameter int CNT_W        = 4,
   parameter int DEFAULT_WAIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_wait,
   input  logic             if_req,
   input  logic             mem_req,
   input  logic             mem_wr,
   output logic             if_gnt,
   output logic             mem_gnt,
   output logic             if_done,
   output logic             mem_done,
   output logic             bus_en,
   output logic             bus_we,
   output logic             stall
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] wait_reg;
   logic             last_mem;
   logic             pick_mem;

   // Arbitration decision for an IDLE cycle; only meaningful when some request is up.
   always_comb begin
      pick_mem = 1'b0;
`ifdef MEM_PRIO_EN
      pick_mem = mem_req;
`else
      pick_mem = mem_req & (~if_req | ~last_mem);
`endif
   end

   assign stall = (if_req & ~if_done) | (mem_req & ~mem_done);

   // Config writes never touch an in-flight cnt; the next grant picks them up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_reg <= CNT_W'(DEFAULT_WAIT);
      end else if (cfg_we) begin
         wait_reg <= cfg_wait;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         last_mem <= 1'b1;
         if_gnt   <= 1'b0;
         mem_gnt  <= 1'b0;
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         bus_en   <= 1'b0;
         bus_we   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req || mem_req) begin
                  state  <= ACCESS;
                  bus_en <= 1'b1;
                  cnt    <= wait_reg;
                  if (pick_mem) begin
                     mem_gnt  <= 1'b1;
                     bus_we   <= mem_wr;
                     last_mem <= 1'b1;
                  end else begin
                     if_gnt   <= 1'b1;
                     bus_we   <= 1'b0;
                     last_mem <= 1'b0;
                  end
               end
            end
            // cnt counts the remaining bus cycles after this one, so bus_en spans wait_reg+1 cycles.
            ACCESS: begin
               if (cnt == '0) begin
                  state    <= DONE;
                  bus_en   <= 1'b0;
                  bus_we   <= 1'b0;
                  if_done  <= if_gnt;
                  mem_done <= mem_gnt;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               if_gnt   <= 1'b0;
               mem_gnt  <= 1'b0;
               if_done  <= 1'b0;
               mem_done <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
